// File: rtl/omsp_hmac_arbiter.sv
// Round-robin, transaction-granular arbiter that shares one HMAC core between NUM_REQ engines.
// The core is held in reset between owners so key material and state never cross an ownership boundary.
module omsp_hmac_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int SCRUB_CYC = 2,
  parameter int MAX_HOLD  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     abort,
  output logic [NUM_REQ-1:0]     req_busy,
  input  logic [NUM_REQ-1:0]     req_hmac_reset,
  input  logic [NUM_REQ-1:0]     req_start_continue,
  input  logic [NUM_REQ-1:0]     req_data_available,
  input  logic [NUM_REQ-1:0]     req_data_is_long,
  input  logic [16*NUM_REQ-1:0]  req_data,
  input  logic [2*NUM_REQ-1:0]   req_key_select,
  input  logic                   hmac_busy,
  output logic                   hmac_reset,
  output logic                   hmac_start_continue,
  output logic                   hmac_data_available,
  output logic                   hmac_data_is_long,
  output logic [15:0]            hmac_data,
  output logic [1:0]             hmac_key_select
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(SCRUB_CYC + 1);
  localparam logic [SW-1:0]      SCRUB_LAST = SW'(SCRUB_CYC - 1);
  localparam logic [15:0]        HOLD_LAST  = 16'(MAX_HOLD - 1);
  localparam logic [OW-1:0]      LAST_RST   = OW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCRUB = 2'd1,
    ST_OWNED = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_q, last_d;
  logic [SW-1:0]        scrub_cnt_q, scrub_cnt_d;
  logic [15:0]          hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   abort_q, abort_d;

  logic                 pick_valid;
  logic [OW-1:0]        pick_idx;

  logic [15:0]          data_arr [NUM_REQ];
  logic [1:0]           key_arr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[16*gi +: 16];
    assign key_arr[gi]  = req_key_select[2*gi +: 2];
  end

  // Round-robin pick: scan last+1, last+2, ... ; descending loop so the nearest candidate wins.
  always_comb begin : p_pick
    int cand;
    cand       = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = OW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      last_q      <= LAST_RST;
      scrub_cnt_q <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      abort_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      scrub_cnt_q <= scrub_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    scrub_cnt_d = scrub_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    abort_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d     = pick_idx;
          scrub_cnt_d = '0;
          state_d     = ST_SCRUB;
        end
      end
      ST_SCRUB: begin
        scrub_cnt_d = scrub_cnt_q + 1'b1;
        if (!req[owner_q]) begin
          state_d = ST_FLUSH;
        end else if (scrub_cnt_q == SCRUB_LAST) begin
          state_d    = ST_OWNED;
          hold_cnt_d = '0;
        end
      end
      ST_OWNED: begin
        if (hold_cnt_q != 16'hFFFF) begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
        if (!req[owner_q]) begin
          state_d = ST_FLUSH;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
          state_d = ST_FLUSH;
          abort_d = ONE_HOT0 << owner_q;
        end
      end
      ST_FLUSH: begin
        last_d = owner_q;
        // Hold the scrub until the core has actually wound down.
        if (!hmac_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    gnt_d = (state_d == ST_OWNED) ? (ONE_HOT0 << owner_d) : '0;
  end

  always_comb begin
    hmac_reset          = 1'b1;
    hmac_start_continue = 1'b0;
    hmac_data_available = 1'b0;
    hmac_data_is_long   = 1'b0;
    hmac_data           = 16'h0000;
    hmac_key_select     = 2'b00;
    req_busy            = '1;
    if (state_q == ST_OWNED) begin
      hmac_reset          = req_hmac_reset[owner_q];
      hmac_start_continue = req_start_continue[owner_q];
      hmac_data_available = req_data_available[owner_q];
      hmac_data_is_long   = req_data_is_long[owner_q];
      hmac_data           = data_arr[owner_q];
      hmac_key_select     = key_arr[owner_q];
      req_busy[owner_q]   = hmac_busy;
    end
  end

  assign gnt   = gnt_q;
  assign abort = abort_q;

endmodule

// File: tb/tb_omsp_hmac_arbiter.sv
// Directed and randomized bench for omsp_hmac_arbiter, checked every cycle against a
// transaction-level reference model (phase + countdown timers).
module tb_omsp_hmac_arbiter;

  localparam int N  = 2;
  localparam int SC = 2;
  localparam int MH = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    r_rst = '0, r_start = '0, r_avail = '0, r_long = '0;
  logic [16*N-1:0] r_data = '0;
  logic [2*N-1:0]  r_key = '0;
  logic            busy = 1'b0;

  logic [N-1:0]    gnt, abort, req_busy;
  logic            h_rst, h_start, h_avail, h_long;
  logic [15:0]     h_data;
  logic [1:0]      h_key;

  omsp_hmac_arbiter #(.NUM_REQ(N), .SCRUB_CYC(SC), .MAX_HOLD(MH)) dut (
    .clk                (clk),
    .reset              (reset),
    .req                (req),
    .gnt                (gnt),
    .abort              (abort),
    .req_busy           (req_busy),
    .req_hmac_reset     (r_rst),
    .req_start_continue (r_start),
    .req_data_available (r_avail),
    .req_data_is_long   (r_long),
    .req_data           (r_data),
    .req_key_select     (r_key),
    .hmac_busy          (busy),
    .hmac_reset         (h_rst),
    .hmac_start_continue(h_start),
    .hmac_data_available(h_avail),
    .hmac_data_is_long  (h_long),
    .hmac_data          (h_data),
    .hmac_key_select    (h_key)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: which phase the shared core is in, who holds it, and countdowns.
  typedef enum int {M_IDLE, M_SCRUB, M_OWNED, M_FLUSH} phase_t;
  phase_t       m_phase;
  int           m_owner, m_last, m_scrub_left, m_held;
  logic [N-1:0] m_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_owner = 0;
    m_last = N - 1;
    m_scrub_left = 0;
    m_held = 0;
    m_abort = '0;
  endtask

  task automatic model_step();
    int c;
    bit found;
    logic [N-1:0] ab;
    found = 1'b0;
    ab = '0;
    case (m_phase)
      M_IDLE: if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && req[c]) begin
            found = 1'b1;
            m_owner = c;
          end
        end
        m_scrub_left = SC;
        m_phase = M_SCRUB;
      end
      M_SCRUB: begin
        if (!req[m_owner]) m_phase = M_FLUSH;
        else begin
          m_scrub_left--;
          if (m_scrub_left == 0) begin
            m_phase = M_OWNED;
            m_held = 0;
          end
        end
      end
      M_OWNED: begin
        m_held++;
        if (!req[m_owner]) m_phase = M_FLUSH;
        else if (MH != 0 && m_held == MH) begin
          m_phase = M_FLUSH;
          ab[m_owner] = 1'b1;
        end
      end
      M_FLUSH: begin
        m_last = m_owner;
        if (!busy) m_phase = M_IDLE;
      end
      default: m_phase = M_IDLE;
    endcase
    m_abort = ab;
  endtask

  task automatic model_check(input string tag);
    bit owned;
    logic [N-1:0] e_gnt, e_busy;
    owned = (m_phase == M_OWNED);
    e_gnt = '0;
    for (int i = 0; i < N; i++) begin
      e_busy[i] = (owned && i == m_owner) ? busy : 1'b1;
      if (owned && i == m_owner) e_gnt[i] = 1'b1;
    end
    chk({tag, ".gnt"},      32'(gnt),      32'(e_gnt));
    chk({tag, ".abort"},    32'(abort),    32'(m_abort));
    chk({tag, ".req_busy"}, 32'(req_busy), 32'(e_busy));
    chk({tag, ".h_rst"},    32'(h_rst),    owned ? 32'(r_rst[m_owner]) : 32'd1);
    chk({tag, ".h_start"},  32'(h_start),  owned ? 32'(r_start[m_owner]) : 32'd0);
    chk({tag, ".h_avail"},  32'(h_avail),  owned ? 32'(r_avail[m_owner]) : 32'd0);
    chk({tag, ".h_long"},   32'(h_long),   owned ? 32'(r_long[m_owner]) : 32'd0);
    chk({tag, ".h_data"},   32'(h_data),   owned ? 32'(r_data[16*m_owner +: 16]) : 32'd0);
    chk({tag, ".h_key"},    32'(h_key),    owned ? 32'(r_key[2*m_owner +: 2]) : 32'd0);
  endtask

  task automatic tick(input string tag);
    #1;
    model_check(tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #2;
    reset = 1'b1;
    req = '0;
    #1;
    chk("rst_mid.gnt", 32'(gnt), 32'd0);
    chk("rst_mid.h_rst", 32'(h_rst), 32'd1);
    chk("rst_mid.abort", 32'(abort), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.abort", 32'(abort), 32'd0);
    chk("rst.h_rst", 32'(h_rst), 32'd1);
    chk("rst.h_data", 32'(h_data), 32'd0);
    chk("rst.req_busy", 32'(req_busy), 32'h3);
    reset = 1'b0;
    tick("idle");

    // Single request: grant after 1 + SC cycles, core scrubbed meanwhile.
    req = 2'b01;
    tick("A.t0");
    chk("A.scrub1.h_rst", 32'(h_rst), 32'd1);
    chk("A.scrub1.gnt", 32'(gnt), 32'd0);
    tick("A.t1");
    chk("A.scrub2.h_rst", 32'(h_rst), 32'd1);
    tick("A.t2");
    r_data = {16'hFFFF, 16'hA5A5};
    r_avail = 2'b01;
    r_start = 2'b10;
    #1;
    chk("A.grant", 32'(gnt), 32'h1);
    chk("A.data", 32'(h_data), 32'hA5A5);
    chk("A.nonowner_start", 32'(h_start), 32'd0);
    chk("A.avail", 32'(h_avail), 32'd1);
    chk("A.req_busy", 32'(req_busy), 32'h2);
    tick("A.own0");
    tick("A.own1");
    reset_mid();
    r_data = '0;
    r_avail = '0;
    r_start = '0;
    tick("A.after_rst");

    // Simultaneous requests from reset, release under busy, round-robin.
    req = 2'b11;
    repeat (3) tick("B.arb");
    chk("B.first", 32'(gnt), 32'h1);
    req = 2'b10;
    busy = 1'b1;
    tick("B.drop");
    for (int i = 0; i < 5; i++) begin
      chk("B.flush.gnt", 32'(gnt), 32'd0);
      chk("B.flush.h_rst", 32'(h_rst), 32'd1);
      tick("B.flush");
    end
    busy = 1'b0;
    repeat (4) tick("B.next");
    chk("B.second", 32'(gnt), 32'h2);
    req = 2'b00;
    repeat (2) tick("B.rel");
    req = 2'b11;
    repeat (3) tick("B.rr");
    chk("B.rr", 32'(gnt), 32'h1);
    req = 2'b00;
    repeat (2) tick("B.rel2");

    // Watchdog: owner 0 holds forever, requester 1 pending.
    req = 2'b01;
    repeat (3) tick("C.arb");
    chk("C.grant", 32'(gnt), 32'h1);
    req = 2'b11;
    repeat (7) tick("C.hold");
    chk("C.pre_abort.gnt", 32'(gnt), 32'h1);
    chk("C.pre_abort.abort", 32'(abort), 32'd0);
    tick("C.last");
    chk("C.abort", 32'(abort), 32'h1);
    chk("C.abort.gnt", 32'(gnt), 32'd0);
    tick("C.flush");
    chk("C.abort_pulse", 32'(abort), 32'd0);
    repeat (3) tick("C.arb2");
    chk("C.pending_grant", 32'(gnt), 32'h2);
    req = 2'b00;
    repeat (2) tick("C.rel");

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      end
      busy    = ($urandom_range(2) == 0);
      r_rst   = N'($urandom);
      r_start = N'($urandom);
      r_avail = N'($urandom);
      r_long  = N'($urandom);
      r_data  = (16*N)'($urandom);
      r_key   = (2*N)'($urandom);
      tick("R");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
